norm_seq_ctrl: RTL and testbench
================================

Name: norm_seq_ctrl

Overview:
Sequencer and result collector on the command side of the single-column-group normalizer. It pops psum vectors from the upstream buffer and drives the normalizer's acc strobes. It then drives the matching div strobes and captures each normalized output vector (qualified by norm_wr) into the output SRAM write port. One start command processes a batch of up to DEPTH vectors and ends with a done pulse.

Parameters:
col, 8, lanes per vector
bw, 8, activation width
bw_psum, 2*bw+4 (20), psum/normalized element width
DEPTH, 16, normalizer FIFO depth = max batch size
addr_bw, 4, output SRAM address width (log2 DEPTH)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  begin batch; sampled only in IDLE
num_vec  in  5  batch length; 0 = empty batch, >DEPTH clamped to DEPTH
base_addr  in  addr_bw  first output SRAM address; latched on start
psum_valid  in  1  upstream psum vector available
psum_rd  out  1  upstream pop, same cycle as acc
acc  out  1  normalizer accumulate/write strobe
div  out  1  normalizer divide/read strobe
norm_wr  in  col  normalizer per-lane result valid
sfp_out  in  bw_psum*col  normalizer result vector
mem_wen  out  1  output SRAM write enable
mem_addr  out  addr_bw  output SRAM address
mem_d  out  bw_psum*col  output SRAM write data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at batch end
err  out  1  sticky; cleared on accepted start

Behaviour:
- Reset: state=IDLE; all counters 0; psum_rd, acc, div, mem_wen, done, err=0; mem_addr=0; mem_d=0.
- States: IDLE, ACC, GAP, DIV, DRAIN, DONE.
- IDLE: start=1 latches n=min(num_vec,DEPTH) and base_addr, clears err and counters. Next state is ACC, or DONE if n=0. start outside IDLE is ignored.
- ACC: acc=psum_rd=psum_valid && acc_cnt<n. These are combinational from the state and registered counters. psum_valid=0 stalls without error. When acc_cnt reaches n, go to GAP.
- GAP: exactly 2 cycles with acc=div=0. This lets the normalizer's registered sum reach its sum FIFO before the first read.
- DIV: div=1 for exactly n consecutive cycles. div_cnt counts them. There is no backpressure. Go to DRAIN after the n-th div.
- Result capture runs in every state: norm_wr==all ones in cycle t gives mem_wen=1 in t+1, with mem_d=sfp_out sampled at t and mem_addr=base_addr+wr_cnt (mod 2^addr_bw); then wr_cnt++.
- A partial norm_wr (non-zero, not all ones) sets err and is still written.
- norm_wr!=0 outside DIV/DRAIN (or DIV cycle+1) sets err and is not written.
- DRAIN: exit to DONE when wr_cnt==n. If wr_cnt<n after 4 cycles in DRAIN, set err and go to DONE.
- DONE: done=1 for one cycle, busy still 1, then IDLE. A start in the DONE cycle is ignored.
- Address wrap: base_addr+wr_cnt wraps modulo 2^addr_bw.
- Reset mid-batch: immediate return to IDLE with all outputs at reset values. The normalizer shares the same reset, so no FIFO state survives.
- Expected normalizer latency: norm_wr arrives 1 cycle after div. The DRAIN window tolerates up to 4 cycles.

Test Plan:
- Reset then start, num_vec=3, base_addr=0, psum_valid always 1 → acc high cycles 1-3, 2 idle GAP cycles, div high 3 cycles. With a normalizer model, mem_wen at addresses 0,1,2 with data equal to sfp_out; done pulses once; err=0.
- num_vec=4 with psum_valid toggling 1,0,1,0,… → exactly 4 acc/psum_rd pulses, only in valid cycles; div count=4; 4 SRAM writes.
- num_vec=20, base_addr=14 → clamped to 16 acc and 16 div; writes at addresses 14,15,0,…,13 (wrap); done once.
- num_vec=0 → no acc/div/mem_wen; busy high 1 cycle; done pulses in the cycle after start.
- Model drops the last norm_wr, or drives norm_wr=8'h0F on vector 1 → err=1 (timeout after 4 DRAIN cycles, or partial write to addr 1); done still pulses; next start clears err.
- Assert reset during DIV of an 8-vector batch → next cycle: IDLE, busy=0, acc=div=mem_wen=0. A new start with num_vec=2 completes cleanly.

Source files
------------

// File: rtl/norm_seq_ctrl.sv
// rtl/norm_seq_ctrl.sv - batch sequencer and result collector for the column-group normalizer
//
// Pops psum vectors from the upstream buffer into the normalizer (acc), waits two
// cycles, then issues one div per vector and writes each normalized vector into
// the output SRAM.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               begin a batch (honoured only in IDLE)
//   num_vec             batch length, clamped to DEPTH; 0 = empty batch
//   base_addr           first output SRAM address, latched on start
//   psum_valid          upstream vector available
//   psum_rd, acc        upstream pop / normalizer accumulate (same cycle)
//   div                 normalizer divide/read strobe
//   norm_wr, sfp_out    normalizer per-lane result valid and result vector
//   mem_wen/addr/d      output SRAM write port (registered)
//   busy, done, err     status: not idle, one-cycle batch end, sticky error
module norm_seq_ctrl #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int DEPTH   = 16,
    parameter int addr_bw = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [4:0]               num_vec,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic                     psum_valid,
    output logic                     psum_rd,
    output logic                     acc,
    output logic                     div,
    input  logic [col-1:0]           norm_wr,
    input  logic [bw_psum*col-1:0]   sfp_out,
    output logic                     mem_wen,
    output logic [addr_bw-1:0]       mem_addr,
    output logic [bw_psum*col-1:0]   mem_d,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACC, S_GAP, S_DIV, S_DRAIN, S_DONE
    } state_t;

    localparam logic [4:0] DEPTH_N = 5'(DEPTH);

    state_t              state;
    logic [4:0]          n;
    logic [4:0]          acc_cnt;
    logic [4:0]          div_cnt;
    logic [4:0]          wr_cnt;
    logic                gap_cnt;
    logic [1:0]          drain_cnt;
    logic [addr_bw-1:0]  base;

    logic acc_fire;
    logic res_window;
    logic res_any;
    logic res_full;

    // acc must answer psum_valid in the same cycle, so it is decoded from the
    // registered state/counters rather than registered itself.
    assign acc_fire = (state == S_ACC) && psum_valid && (acc_cnt < n);
    assign acc      = acc_fire;
    assign psum_rd  = acc_fire;
    assign div      = (state == S_DIV);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    // Results arrive one cycle after div, so the last one lands in DRAIN;
    // anything outside DIV/DRAIN is a stray strobe.
    assign res_window = (state == S_DIV) || (state == S_DRAIN);
    assign res_any    = |norm_wr;
    assign res_full   = &norm_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            n         <= '0;
            acc_cnt   <= '0;
            div_cnt   <= '0;
            wr_cnt    <= '0;
            gap_cnt   <= 1'b0;
            drain_cnt <= '0;
            base      <= '0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_d     <= '0;
            err       <= 1'b0;
        end else begin
            mem_wen <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        n         <= (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
                        base      <= base_addr;
                        acc_cnt   <= '0;
                        div_cnt   <= '0;
                        wr_cnt    <= '0;
                        gap_cnt   <= 1'b0;
                        drain_cnt <= '0;
                        err       <= 1'b0;
                        state     <= (num_vec == 5'd0) ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    if (acc_fire) begin
                        acc_cnt <= acc_cnt + 5'd1;
                        if (acc_cnt + 5'd1 == n)
                            state <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Two dead cycles let the normalizer's registered sum reach its FIFO.
                    gap_cnt <= ~gap_cnt;
                    if (gap_cnt)
                        state <= S_DIV;
                end
                S_DIV: begin
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt + 5'd1 == n)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (wr_cnt == n) begin
                        state <= S_DONE;
                    end else if (drain_cnt == 2'd3) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Result capture runs independently of the sequencing above.
            if (res_any) begin
                if (res_window) begin
                    mem_wen  <= 1'b1;
                    mem_addr <= base + wr_cnt[addr_bw-1:0];
                    mem_d    <= sfp_out;
                    wr_cnt   <= wr_cnt + 5'd1;
                    if (!res_full)
                        err <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// tb/tb_norm_seq_ctrl.sv - self-checking bench for norm_seq_ctrl
module tb_norm_seq_ctrl;

    localparam int COL = 8;
    localparam int BWP = 20;
    localparam int DW  = COL*BWP;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [4:0]      num_vec = '0;
    logic [3:0]      base_addr = '0;
    logic            psum_valid = 1'b0;
    logic            psum_rd, acc, div;
    logic [COL-1:0]  norm_wr;
    logic [DW-1:0]   sfp_out;
    logic            mem_wen;
    logic [3:0]      mem_addr;
    logic [DW-1:0]   mem_d;
    logic            busy, done, err;

    norm_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
        .base_addr(base_addr), .psum_valid(psum_valid), .psum_rd(psum_rd),
        .acc(acc), .div(div), .norm_wr(norm_wr), .sfp_out(sfp_out),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_d(mem_d),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int v);
        logic [DW-1:0] r;
        for (int l = 0; l < COL; l++)
            r[l*BWP +: BWP] = BWP'(v*256 + l*17 + 5);
        return r;
    endfunction

    // Normalizer model: full result one cycle after each div.
    int cur_n = 0;
    int drop_last = 0;
    int partial_idx = -1;
    int vec_idx = 0;

    always @(posedge clk) begin
        if (reset || !busy) begin
            vec_idx <= 0;
            norm_wr <= '0;
            sfp_out <= '0;
        end else begin
            norm_wr <= '0;
            if (div) begin
                vec_idx <= vec_idx + 1;
                sfp_out <= pat(vec_idx);
                if (drop_last != 0 && vec_idx == cur_n - 1)
                    norm_wr <= '0;
                else if (vec_idx == partial_idx)
                    norm_wr <= 8'h0F;
                else
                    norm_wr <= 8'hFF;
            end
        end
    end

    // Monitor, sampled 1 time unit after each rising edge.
    int mon_en = 0;
    int toggle = 0;
    int cyc, n_acc, n_div, n_done, n_busy, bad_acc, bad_rd;
    int first_acc, last_acc, first_div, last_div, done_cyc;
    int wr_addr[$];
    logic [DW-1:0] wr_data[$];

    always @(posedge clk) begin
        #1;
        if (mon_en != 0) begin
            cyc++;
            if (acc) begin
                n_acc++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (!psum_valid) bad_acc++;
            end
            if (acc != psum_rd) bad_rd++;
            if (div) begin
                n_div++;
                if (first_div < 0) first_div = cyc;
                last_div = cyc;
            end
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (mem_wen) begin
                wr_addr.push_back(int'(mem_addr));
                wr_data.push_back(mem_d);
            end
            psum_valid = (toggle != 0) ? ~psum_valid : 1'b1;
        end
    end

    task automatic run_batch(input int nv, input int base, input int tog,
                             input int drop, input int part, input int expn);
        @(negedge clk);
        cyc = 0; n_acc = 0; n_div = 0; n_done = 0; n_busy = 0;
        bad_acc = 0; bad_rd = 0; first_acc = -1; last_acc = -1;
        first_div = -1; last_div = -1; done_cyc = -1;
        wr_addr.delete(); wr_data.delete();
        cur_n = expn; drop_last = drop; partial_idx = part; toggle = tog;
        num_vec = 5'(nv); base_addr = 4'(base); psum_valid = 1'b1;
        start = 1'b1; mon_en = 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 300 && n_done == 0; i++) @(negedge clk);
        if (n_done == 0) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        mon_en = 0;
    endtask

    typedef struct {
        int nv; int base; int tog; int drop; int part;
        int exp_n; int exp_wr; int exp_err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{3,  0,  0, 0, -1, 3,  3,  0};
        tbl[1] = '{4,  5,  1, 0, -1, 4,  4,  0};
        tbl[2] = '{20, 14, 0, 0, -1, 16, 16, 0};
        tbl[3] = '{0,  3,  0, 0, -1, 0,  0,  0};
        tbl[4] = '{4,  2,  0, 1, -1, 4,  3,  1};
        tbl[5] = '{3,  0,  0, 0,  1, 3,  3,  1};
        tbl[6] = '{16, 0,  1, 0, -1, 16, 16, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_acc_div", int'({acc, div, psum_rd}), 0);
        chk("rst_wen_done_err", int'({mem_wen, done, err}), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk_v("rst_mem_d", mem_d, '0);
        @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < 7; t++) begin
            run_batch(tbl[t].nv, tbl[t].base, tbl[t].tog, tbl[t].drop,
                      tbl[t].part, tbl[t].exp_n);
            chk($sformatf("t%0d_acc", t), n_acc, tbl[t].exp_n);
            chk($sformatf("t%0d_div", t), n_div, tbl[t].exp_n);
            chk($sformatf("t%0d_acc_wo_valid", t), bad_acc, 0);
            chk($sformatf("t%0d_rd_ne_acc", t), bad_rd, 0);
            chk($sformatf("t%0d_done", t), n_done, 1);
            chk($sformatf("t%0d_err", t), int'(err), tbl[t].exp_err);
            chk($sformatf("t%0d_nwr", t), wr_addr.size(), tbl[t].exp_wr);
            for (int i = 0; i < wr_addr.size() && i < tbl[t].exp_wr; i++) begin
                chk($sformatf("t%0d_addr%0d", t, i), wr_addr[i], (tbl[t].base + i) % 16);
                chk_v($sformatf("t%0d_data%0d", t, i), wr_data[i], pat(i));
            end
            if (t == 0) begin
                chk("t0_first_acc", first_acc, 1);
                chk("t0_last_acc", last_acc, 3);
                chk("t0_first_div", first_div, 6);
                chk("t0_last_div", last_div, 8);
            end
            if (t == 3) begin
                chk("t3_busy_cycles", n_busy, 1);
                chk("t3_done_cyc", done_cyc, 1);
            end
        end

        // Reset asserted while dividing an 8-vector batch.
        @(negedge clk);
        cur_n = 8; drop_last = 0; partial_idx = -1; toggle = 0;
        num_vec = 5'd8; base_addr = 4'd0; psum_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !div; i++) @(negedge clk);
        chk("rst_mid_in_div", int'(div), 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_strobes", int'({acc, div, mem_wen, done}), 0);
        @(negedge clk);
        reset = 1'b0;
        run_batch(2, 7, 0, 0, -1, 2);
        chk("post_rst_acc", n_acc, 2);
        chk("post_rst_div", n_div, 2);
        chk("post_rst_nwr", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            chk("post_rst_addr1", wr_addr[1], 8);
            chk_v("post_rst_data1", wr_data[1], pat(1));
        end
        chk("post_rst_done", n_done, 1);
        chk("post_rst_err", int'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
